// File: rtl/evt_pkg.sv
// Shared definitions for the event source and the event counters it drives:
// FSM state encoding and default count/gap widths.
package evt_pkg;

  localparam int MAX_COUNT_DEF = 6;
  localparam int MAX_GAP_DEF   = 15;
  localparam int CW            = $clog2(MAX_COUNT_DEF + 1);
  localparam int GW            = $clog2(MAX_GAP_DEF + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PULSE = 2'd1,
    GAP   = 2'd2,
    ZDONE = 2'd3
  } evt_state_e;

endpackage

// File: rtl/evt_gap_timer.sv
// Loadable down-counter timing the idle cycles between pulses.
// Loading value N makes expired_out rise in the N-th cycle after the load,
// so the owner leaves its wait state after exactly N cycles.
module evt_gap_timer
  import evt_pkg::*;
#(
  parameter int W = GW
) (
  input  logic         clk_in,
  input  logic         rst_n_in,
  input  logic         load_in,
  input  logic [W-1:0] value_in,
  output logic         expired_out
);

  logic [W-1:0] cnt_q;

  // Load on request, otherwise count down and park at zero.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      cnt_q <= '0;
    end else if (load_in) begin
      cnt_q <= value_in;
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - W'(1);
    end
  end

  assign expired_out = (cnt_q <= W'(1));

endmodule

// File: rtl/evt_burst_gen.sv
// Burst event source: accepts (count, gap) over valid/ready, then emits
// count single-cycle pulses spaced gap+1 cycles apart, flagging the last
// one on done_out. A zero-count burst produces a lone done_out.
module evt_burst_gen
  import evt_pkg::*;
#(
  parameter  int MAX_COUNT = MAX_COUNT_DEF,
  parameter  int MAX_GAP   = MAX_GAP_DEF,
  localparam int CNT_W     = $clog2(MAX_COUNT + 1),
  localparam int GAP_W     = $clog2(MAX_GAP + 1)
) (
  input  logic             clk_in,
  input  logic             rst_n_in,
  input  logic             cmd_valid_in,
  output logic             cmd_ready_out,
  input  logic [CNT_W-1:0] cmd_count_in,
  input  logic [GAP_W-1:0] cmd_gap_in,
  input  logic             abort_in,
  output logic             evt_out,
  output logic [CNT_W-1:0] pulse_idx_out,
  output logic             busy_out,
  output logic             done_out
);

  evt_state_e       state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [GAP_W-1:0] gap_q;
  logic [CNT_W-1:0] cmd_cnt_sat;
  logic [GAP_W-1:0] cmd_gap_sat;
  logic [CNT_W-1:0] next_idx;
  logic             accept;
  logic             last_pulse;
  logic             next_is_last;
  logic             gap_load;
  logic             gap_expired;

  function automatic logic [CNT_W-1:0] sat_count(input logic [CNT_W-1:0] v);
    if (v > CNT_W'(MAX_COUNT)) return CNT_W'(MAX_COUNT);
    return v;
  endfunction

  function automatic logic [GAP_W-1:0] sat_gap(input logic [GAP_W-1:0] v);
    if (v > GAP_W'(MAX_GAP)) return GAP_W'(MAX_GAP);
    return v;
  endfunction

  assign cmd_ready_out = (state_q == IDLE);
  assign accept        = cmd_valid_in && cmd_ready_out;
  assign cmd_cnt_sat   = sat_count(cmd_count_in);
  assign cmd_gap_sat   = sat_gap(cmd_gap_in);
  assign next_idx      = pulse_idx_out + CNT_W'(1);
  assign next_is_last  = ((next_idx + CNT_W'(1)) == cnt_q);
  assign last_pulse    = (state_q == PULSE) && (next_idx == cnt_q);
  // The timer is armed while the pulse preceding a gap is on the wire.
  assign gap_load      = (state_q == PULSE) && !last_pulse && !abort_in
                         && (gap_q != '0);

  evt_gap_timer #(
    .W (GAP_W)
  ) u_gap_timer (
    .clk_in      (clk_in),
    .rst_n_in    (rst_n_in),
    .load_in     (gap_load),
    .value_in    (gap_q),
    .expired_out (gap_expired)
  );

  // Capture the saturated command; held untouched for the whole burst.
  always_ff @(posedge clk_in) begin
    if (accept) begin
      cnt_q <= cmd_cnt_sat;
      gap_q <= cmd_gap_sat;
    end
  end

  // Burst sequencer; outputs are registered with the state they describe.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q       <= IDLE;
      evt_out       <= 1'b0;
      pulse_idx_out <= '0;
      busy_out      <= 1'b0;
      done_out      <= 1'b0;
    end else begin
      evt_out  <= 1'b0;
      done_out <= 1'b0;
      case (state_q)
        IDLE: begin
          if (accept) begin
            busy_out      <= 1'b1;
            pulse_idx_out <= '0;
            if (cmd_cnt_sat == '0) begin
              state_q  <= ZDONE;
              done_out <= 1'b1;
            end else begin
              state_q  <= PULSE;
              evt_out  <= 1'b1;
              done_out <= (cmd_cnt_sat == CNT_W'(1));
            end
          end
        end
        PULSE: begin
          // The final pulse wins over abort: its done_out is already out.
          if (last_pulse || abort_in) begin
            state_q       <= IDLE;
            busy_out      <= 1'b0;
            pulse_idx_out <= '0;
          end else if (gap_q == '0) begin
            evt_out       <= 1'b1;
            pulse_idx_out <= next_idx;
            done_out      <= next_is_last;
          end else begin
            state_q <= GAP;
          end
        end
        GAP: begin
          if (abort_in) begin
            state_q       <= IDLE;
            busy_out      <= 1'b0;
            pulse_idx_out <= '0;
          end else if (gap_expired) begin
            state_q       <= PULSE;
            evt_out       <= 1'b1;
            pulse_idx_out <= next_idx;
            done_out      <= next_is_last;
          end
        end
        ZDONE: begin
          state_q  <= IDLE;
          busy_out <= 1'b0;
        end
        default: begin
          state_q  <= IDLE;
          busy_out <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/evt_burst_gen.md
Name: evt_burst_gen

Overview:
Event source paired with the event counter. It accepts a burst command over a valid/ready handshake. It then emits exactly N single-cycle pulses on evt_out, separated by a programmable number of idle cycles, and flags the last pulse on done_out. It drives counter evt inputs in the video and depth paths, and acts as the stimulus generator in counter benches.

Parameters:
MAX_COUNT, 6, maximum pulses per burst; count width CW = $clog2(MAX_COUNT+1)
MAX_GAP, 15, maximum idle cycles between pulses; gap width GW = $clog2(MAX_GAP+1)

Ports:
clk_in  input  1  system clock, all logic on rising edge
rst_n_in  input  1  asynchronous active-low reset
cmd_valid_in  input  1  burst command present
cmd_ready_out  output  1  block can accept a command
cmd_count_in  input  CW  pulses in burst, 0..MAX_COUNT
cmd_gap_in  input  GW  idle cycles between consecutive pulses, 0..MAX_GAP
abort_in  input  1  terminate the current burst
evt_out  output  1  single-cycle event pulse
pulse_idx_out  output  CW  index of the current pulse, 0-based; valid while evt_out=1
busy_out  output  1  burst in progress
done_out  output  1  one-cycle flag coincident with the last pulse of a completed burst

Behaviour:
- Reset (rst_n_in=0, asynchronous): state IDLE, evt_out=0, pulse_idx_out=0, busy_out=0, done_out=0, cmd_ready_out=1 after reset release. Reset asserted mid-burst abandons the burst immediately; no done_out.
- All outputs are registered except cmd_ready_out, which is decoded from state and is 1 only in IDLE.
- FSM states: IDLE, PULSE, GAP, ZDONE.
- IDLE: on cmd_valid_in && cmd_ready_out at edge T:
  - latch count and gap;
  - count>0: go to PULSE; first evt_out=1 in cycle T+1, pulse_idx_out=0.
  - count=0: go to ZDONE.
- ZDONE: done_out=1 for one cycle with evt_out=0, then IDLE.
- PULSE: evt_out=1 for exactly one cycle and busy_out=1.
  - If this is pulse count-1: done_out=1 in the same cycle, next state IDLE.
  - Else if gap=0: stay in PULSE with index+1, giving back-to-back pulses.
  - Else: go to GAP.
- GAP: evt_out=0, busy_out=1, gap counter runs gap cycles, then PULSE with index+1.
- Pulse spacing: rising pulses are exactly gap+1 cycles apart. Total burst length is count + (count-1)*gap cycles.
- Back-to-back commands: cmd_ready_out=1 in the cycle after the last pulse. A command accepted then starts its first pulse one cycle later, giving a minimum 1 idle cycle between bursts.
- Command inputs are ignored while cmd_ready_out=0. Latched values are immune to input changes mid-burst.
- Out-of-range inputs: cmd_count_in>MAX_COUNT saturates to MAX_COUNT. cmd_gap_in>MAX_GAP saturates to MAX_GAP.
- abort_in=1 in PULSE or GAP: next state IDLE, no further pulses, done_out stays 0.
  - An evt_out already high in the abort cycle completes normally, since it is registered.
  - abort_in in IDLE has no effect; a command presented in the same cycle is still accepted.
  - If abort_in coincides with the final pulse, that pulse and its done_out still occur.
- Invariants:
  - evt_out is never high on two consecutive cycles unless gap=0.
  - done_out is never high without evt_out, except in the ZDONE case.
- Downstream contract: feeding evt_out into the event counter configured with MAX_COUNT=N gives hit_max_out exactly one cycle after done_out.

Decomposition:
- Shared package evt_pkg holds the FSM state enum (IDLE, PULSE, GAP, ZDONE) and the width helper constants CW and GW. Downstream counters reuse the same package.
- One sub-module is natural: evt_gap_timer, a loadable down-counter with load_in, value_in and expired_out, used for the GAP wait.

Test Plan:
- Reset, then count=3, gap=2 accepted at cycle 0:
  - evt_out high at cycles 1, 4, 7 with pulse_idx_out 0, 1, 2;
  - done_out at cycle 7; busy_out 1..7; cmd_ready_out=1 at cycle 8.
- count=4, gap=0: evt_out high on cycles 1–4 continuously, done_out at cycle 4; loopback into counter (MAX_COUNT=4) gives hit_max_out at cycle 5.
- count=0: no evt_out; done_out at cycle 1 only; ready again at cycle 2.
- count=6, gap=3 with abort_in at cycle 6:
  - pulses at 1 and 5 only; done_out never asserted; ready at cycle 7.
- Two commands held valid continuously (count=2/gap=1, then count=1/gap=0):
  - pulses at 1 and 3, done_out at 3;
  - second command accepted at 4, pulse at 5 with done_out at 5.
- rst_n_in pulled low asynchronously mid-GAP: all outputs 0 immediately, with no clock edge needed; burst abandoned, ready after release.
